game_sequencer: RTL and testbench

Top-level game flow controller for the VGA dodge game. It debounces the start and pause buttons and runs the IDLE/COUNTDOWN/PLAY/PAUSE/OVER state machine. It also generates the frame-rate `mv` step pulse and drives `current_state` into the obstacle/player datapath. It consumes the datapath's `die` flag to track lives and decide between a new round and game over.

---
 rtl/game_sequencer_if.sv | 24 ++
 rtl/game_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_game_sequencer.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/game_sequencer_if.sv
// Button, collision and status signals between the dodge-game sequencer and its environment.
interface game_sequencer_if;
    logic       start_btn;
    logic       pause_btn;
    logic       die;
    logic       mv;
    logic       current_state;
    logic [2:0] game_state;
    logic [1:0] lives;
    logic [7:0] cd_ticks;
    logic       game_over;

    // Environment side: drives buttons and the collision flag, observes game status.
    modport master (
        output start_btn, pause_btn, die,
        input  mv, current_state, game_state, lives, cd_ticks, game_over
    );

    // Sequencer side.
    modport slave (
        input  start_btn, pause_btn, die,
        output mv, current_state, game_state, lives, cd_ticks, game_over
    );
endinterface

// File: rtl/game_sequencer.sv
// Game flow controller for the VGA dodge game: button conditioning, tick timing and round/lives FSM.
// Optional pause feature is compiled in with `define GAME_PAUSE_EN.
module game_sequencer #(
    parameter int unsigned TICK_DIV        = 1666667,
    parameter int unsigned DEB_CYCLES      = 1000000,
    parameter int unsigned COUNTDOWN_TICKS = 180,
    parameter int unsigned OVER_TICKS      = 120,
    parameter int unsigned LIVES           = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    game_sequencer_if.slave        bus
);

    localparam int unsigned TICK_W = $clog2(TICK_DIV);
    localparam int unsigned DEB_W  = $clog2(DEB_CYCLES + 1);

    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(TICK_DIV - 1);
    localparam logic [DEB_W-1:0]  DEB_LAST   = DEB_W'(DEB_CYCLES - 1);
    localparam logic [7:0]        CD_INIT    = 8'(COUNTDOWN_TICKS);
    localparam logic [7:0]        OVER_INIT  = 8'(OVER_TICKS);
    localparam logic [1:0]        LIVES_INIT = 2'(LIVES);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_COUNTDOWN = 3'd1,
        S_PLAY      = 3'd2,
        S_PAUSE     = 3'd3,
        S_OVER      = 3'd4
    } state_t;

    state_t              state;
    logic [7:0]          timer;
    logic [1:0]          lives_r;
    logic [TICK_W-1:0]   tick_cnt;
    logic                die_q;
    logic                mv_r;
    logic                cur_r;
    logic                over_r;
    logic                tick;
    logic                die_rise;

    logic [1:0]          start_sync;
    logic                start_deb;
    logic                start_deb_q;
    logic                start_press;
    logic [DEB_W-1:0]    start_cnt;

    // Start button: synchronize, debounce, then register a one-cycle rising-edge pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_sync  <= '0;
            start_deb   <= 1'b0;
            start_deb_q <= 1'b0;
            start_press <= 1'b0;
            start_cnt   <= '0;
        end else begin
            start_sync  <= {start_sync[0], bus.start_btn};
            start_deb_q <= start_deb;
            start_press <= start_deb & ~start_deb_q;
            if (start_sync[1] == start_deb) begin
                start_cnt <= '0;
            end else if (start_cnt == DEB_LAST) begin
                start_deb <= start_sync[1];
                start_cnt <= '0;
            end else begin
                start_cnt <= start_cnt + DEB_W'(1);
            end
        end
    end

`ifdef GAME_PAUSE_EN
    logic [1:0]          pause_sync;
    logic                pause_deb;
    logic                pause_deb_q;
    logic                pause_press;
    logic [DEB_W-1:0]    pause_cnt;

    // Pause button: same conditioning chain as start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pause_sync  <= '0;
            pause_deb   <= 1'b0;
            pause_deb_q <= 1'b0;
            pause_press <= 1'b0;
            pause_cnt   <= '0;
        end else begin
            pause_sync  <= {pause_sync[0], bus.pause_btn};
            pause_deb_q <= pause_deb;
            pause_press <= pause_deb & ~pause_deb_q;
            if (pause_sync[1] == pause_deb) begin
                pause_cnt <= '0;
            end else if (pause_cnt == DEB_LAST) begin
                pause_deb <= pause_sync[1];
                pause_cnt <= '0;
            end else begin
                pause_cnt <= pause_cnt + DEB_W'(1);
            end
        end
    end
`endif

    assign tick     = (tick_cnt == TICK_LAST);
    assign die_rise = bus.die & ~die_q;

    // Game FSM; status outputs are updated on the same edge as the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            timer    <= '0;
            lives_r  <= '0;
            tick_cnt <= '0;
            die_q    <= 1'b0;
            mv_r     <= 1'b0;
            cur_r    <= 1'b0;
            over_r   <= 1'b0;
        end else begin
            die_q    <= bus.die;
            mv_r     <= tick & (state == S_PLAY);
            tick_cnt <= tick ? '0 : tick_cnt + TICK_W'(1);

            case (state)
                S_IDLE: begin
                    if (start_press) begin
                        state    <= S_COUNTDOWN;
                        timer    <= CD_INIT;
                        lives_r  <= LIVES_INIT;
                        tick_cnt <= '0;
                        cur_r    <= 1'b0;
                        over_r   <= 1'b0;
                    end
                end

                S_COUNTDOWN: begin
                    if (tick) begin
                        if (timer <= 8'd1) begin
                            state <= S_PLAY;
                            timer <= '0;
                            cur_r <= 1'b1;
                        end else begin
                            timer <= timer - 8'd1;
                        end
                    end
                end

                // A collision outranks a simultaneous pause request.
                S_PLAY: begin
                    if (die_rise) begin
                        tick_cnt <= '0;
                        cur_r    <= 1'b0;
                        if (lives_r <= 2'd1) begin
                            state   <= S_OVER;
                            lives_r <= '0;
                            timer   <= OVER_INIT;
                            over_r  <= 1'b1;
                        end else begin
                            state   <= S_COUNTDOWN;
                            lives_r <= lives_r - 2'd1;
                            timer   <= CD_INIT;
                        end
                    end
`ifdef GAME_PAUSE_EN
                    else if (pause_press) begin
                        state <= S_PAUSE;
                    end
`endif
                end

`ifdef GAME_PAUSE_EN
                S_PAUSE: begin
                    if (pause_press) begin
                        state <= S_PLAY;
                    end
                end
`endif

                S_OVER: begin
                    if (start_press && (timer == 8'd0)) begin
                        state    <= S_COUNTDOWN;
                        timer    <= CD_INIT;
                        lives_r  <= LIVES_INIT;
                        tick_cnt <= '0;
                        cur_r    <= 1'b0;
                        over_r   <= 1'b0;
                    end else if (tick && (timer != 8'd0)) begin
                        timer <= timer - 8'd1;
                    end
                end

                // Unused encodings (and PAUSE when not built in) recover to IDLE.
                default: begin
                    state   <= S_IDLE;
                    timer   <= '0;
                    lives_r <= '0;
                    cur_r   <= 1'b0;
                    over_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mv            = mv_r;
    assign bus.current_state = cur_r;
    assign bus.game_state    = state;
    assign bus.lives         = lives_r;
    assign bus.cd_ticks      = timer;
    assign bus.game_over     = over_r;

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed step table, mv/reset sequences, and randomized run against a game-rule model.
module tb_game_sequencer;

    localparam int TD  = 4;
    localparam int DEB = 2;
    localparam int CT  = 3;
    localparam int OT  = 2;
    localparam int LV  = 2;

`ifdef GAME_PAUSE_EN
    localparam bit PAUSE_EN = 1'b1;
`else
    localparam bit PAUSE_EN = 1'b0;
`endif

    localparam int G_IDLE = 0, G_CD = 1, G_PLAY = 2, G_PAUSE = 3, G_OVER = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    game_sequencer_if gif();

    game_sequencer #(
        .TICK_DIV(TD), .DEB_CYCLES(DEB), .COUNTDOWN_TICKS(CT),
        .OVER_TICKS(OT), .LIVES(LV)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(gif)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One directed step: hold inputs for n clocks, then expect this status.
    typedef struct {
        bit st;
        bit pa;
        bit di;
        int n;
        int gs;
        int lv;
        int cd;
        bit mv_chk;
        bit mv;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit st, bit pa, bit di, int n, int gs, int lv, int cd, bit mv_chk, bit mv);
        vec_t v;
        v.st = st; v.pa = pa; v.di = di; v.n = n;
        v.gs = gs; v.lv = lv; v.cd = cd; v.mv_chk = mv_chk; v.mv = mv;
        return v;
    endfunction

    // ---------------- reference model (game rules, cycle by cycle) ----------------
    int m_state, m_timer, m_lives, m_phase;
    bit m_mv, m_die_prev;
    bit sq_s[$], sq_p[$];
    bit rose_s[$], rose_p[$];
    bit lvl_s, lvl_p;
    int run_s, run_p;

    task automatic model_reset();
        m_state = G_IDLE; m_timer = 0; m_lives = 0; m_phase = 0;
        m_mv = 1'b0; m_die_prev = 1'b0;
        sq_s = '{1'b0, 1'b0}; sq_p = '{1'b0, 1'b0};
        rose_s = '{1'b0, 1'b0}; rose_p = '{1'b0, 1'b0};
        lvl_s = 1'b0; lvl_p = 1'b0; run_s = 0; run_p = 0;
    endtask

    // Accept a new level after DEB consecutive differing samples; report a rise.
    task automatic debounce(input bit s, inout bit lvl, inout int run, output bit rose);
        rose = 1'b0;
        if (s != lvl) begin
            run++;
            if (run == DEB) begin
                lvl  = s;
                run  = 0;
                rose = s;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_new_game();
        m_state = G_CD; m_timer = CT; m_lives = LV; m_phase = 0;
    endtask

    task automatic model_step(input bit st, input bit pa, input bit dd);
        bit s_sync, p_sync, press_s, press_p, r_s, r_p, tck, die_rise;
        s_sync = sq_s.pop_front(); sq_s.push_back(st);
        p_sync = sq_p.pop_front(); sq_p.push_back(pa);
        press_s = rose_s.pop_front();
        press_p = rose_p.pop_front();
        debounce(s_sync, lvl_s, run_s, r_s);
        debounce(p_sync, lvl_p, run_p, r_p);
        rose_s.push_back(r_s);
        rose_p.push_back(r_p);

        tck      = (m_phase == TD - 1);
        m_mv     = tck && (m_state == G_PLAY);
        m_phase  = tck ? 0 : m_phase + 1;
        die_rise = dd && !m_die_prev;
        m_die_prev = dd;

        case (m_state)
            G_IDLE: if (press_s) model_new_game();
            G_CD: if (tck) begin
                m_timer--;
                if (m_timer == 0) m_state = G_PLAY;
            end
            G_PLAY: begin
                if (die_rise) begin
                    m_lives--;
                    m_phase = 0;
                    if (m_lives == 0) begin
                        m_state = G_OVER; m_timer = OT;
                    end else begin
                        m_state = G_CD; m_timer = CT;
                    end
                end else if (PAUSE_EN && press_p) begin
                    m_state = G_PAUSE;
                end
            end
            G_PAUSE: if (press_p) m_state = G_PLAY;
            G_OVER: begin
                if (press_s && m_timer == 0) model_new_game();
                else if (tck && m_timer > 0) m_timer--;
            end
            default: m_state = G_IDLE;
        endcase
    endtask

    function automatic logic [15:0] model_out();
        return {3'(m_state), 2'(m_lives), 8'(m_timer),
                1'((m_state == G_PLAY) || (m_state == G_PAUSE)),
                1'(m_state == G_OVER), 1'(m_mv)};
    endfunction

    function automatic logic [15:0] dut_out();
        return {gif.game_state, gif.lives, gif.cd_ticks, gif.current_state, gif.game_over, gif.mv};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        int highs, last, gap_bad;
        int hs, hp, hd;
        bit st_v, pa_v, di_v;

        gif.start_btn = 1'b0;
        gif.pause_btn = 1'b0;
        gif.die       = 1'b0;

        // Directed steps with hand-derived expectations.
        vecs.push_back(mk(0,0,0, 3, G_IDLE, 0, 0, 1, 0));
        vecs.push_back(mk(1,0,0, 1, G_IDLE, 0, 0, 1, 0));   // one-cycle glitch
        vecs.push_back(mk(0,0,0, 6, G_IDLE, 0, 0, 1, 0));
        vecs.push_back(mk(1,0,0, 6, G_CD,   2, 3, 1, 0));   // press after 6 clocks
        vecs.push_back(mk(0,0,0, 4, G_CD,   2, 2, 1, 0));
        vecs.push_back(mk(0,0,0, 4, G_CD,   2, 1, 1, 0));
        vecs.push_back(mk(0,0,0, 3, G_CD,   2, 1, 1, 0));
        vecs.push_back(mk(0,0,0, 1, G_PLAY, 2, 0, 1, 0));
        vecs.push_back(mk(0,0,0, 3, G_PLAY, 2, 0, 1, 0));
        vecs.push_back(mk(0,0,0, 1, G_PLAY, 2, 0, 1, 1));   // first mv
        vecs.push_back(mk(0,0,0, 1, G_PLAY, 2, 0, 1, 0));
        vecs.push_back(mk(0,0,0, 3, G_PLAY, 2, 0, 1, 1));
        vecs.push_back(mk(0,0,1, 1, G_CD,   1, 3, 1, 0));   // die: lose a life
        vecs.push_back(mk(0,0,1, 4, G_CD,   1, 2, 1, 0));   // still high: no further loss
        vecs.push_back(mk(0,0,0, 8, G_PLAY, 1, 0, 1, 0));
        vecs.push_back(mk(0,0,1, 1, G_OVER, 0, 2, 1, 0));   // last life
        vecs.push_back(mk(1,0,0, 6, G_OVER, 0, 1, 1, 0));   // early restart discarded
        vecs.push_back(mk(0,0,0,10, G_OVER, 0, 0, 1, 0));
        vecs.push_back(mk(1,0,0, 6, G_CD,   2, 3, 1, 0));   // restart accepted
        vecs.push_back(mk(0,0,0,12, G_PLAY, 2, 0, 1, 0));
`ifdef GAME_PAUSE_EN
        vecs.push_back(mk(0,1,0, 6, G_PAUSE, 2, 0, 1, 0));
        vecs.push_back(mk(0,0,1, 2, G_PAUSE, 2, 0, 1, 0));  // die ignored
        vecs.push_back(mk(0,0,0, 8, G_PAUSE, 2, 0, 1, 0));  // no mv while paused
        vecs.push_back(mk(0,1,1, 6, G_PLAY,  2, 0, 0, 0));  // resume with die already high
        vecs.push_back(mk(0,0,1, 2, G_PLAY,  2, 0, 0, 0));
        vecs.push_back(mk(0,0,0, 6, G_PLAY,  2, 0, 0, 0));
        vecs.push_back(mk(0,1,0, 5, G_PLAY,  2, 0, 0, 0));
        vecs.push_back(mk(0,1,1, 1, G_CD,    1, 3, 1, 0));  // die beats pause
        vecs.push_back(mk(0,0,0,12, G_PLAY,  1, 0, 1, 0));
`endif

        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(dut_out()), 32'h0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            gif.start_btn = vecs[i].st;
            gif.pause_btn = vecs[i].pa;
            gif.die       = vecs[i].di;
            repeat (vecs[i].n) @(posedge clk);
            @(negedge clk);
            check($sformatf("row%0d_game_state", i), 32'(gif.game_state), 32'(vecs[i].gs));
            check($sformatf("row%0d_lives", i), 32'(gif.lives), 32'(vecs[i].lv));
            check($sformatf("row%0d_cd_ticks", i), 32'(gif.cd_ticks), 32'(vecs[i].cd));
            check($sformatf("row%0d_current_state", i), 32'(gif.current_state),
                  32'((vecs[i].gs == G_PLAY) || (vecs[i].gs == G_PAUSE)));
            check($sformatf("row%0d_game_over", i), 32'(gif.game_over), 32'(vecs[i].gs == G_OVER));
            if (vecs[i].mv_chk)
                check($sformatf("row%0d_mv", i), 32'(gif.mv), 32'(vecs[i].mv));
        end
        gif.start_btn = 1'b0;
        gif.pause_btn = 1'b0;
        gif.die       = 1'b0;

        // mv in PLAY: one-cycle pulses spaced TD apart.
        highs = 0; last = -1; gap_bad = 0;
        for (int c = 0; c < 4 * TD; c++) begin
            @(negedge clk);
            if (gif.mv) begin
                highs++;
                if (last >= 0 && (c - last) != TD) gap_bad++;
                last = c;
            end
        end
        check("mv_pulse_count", 32'(highs), 32'd4);
        check("mv_period_errors", 32'(gap_bad), 32'd0);

        // Asynchronous reset mid-PLAY clears outputs before the next edge.
        @(negedge clk);
        check("pre_reset_in_play", 32'(gif.current_state), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset_outputs", 32'(dut_out()), 32'h0);
        repeat (2) @(negedge clk);
        check("held_reset_outputs", 32'(dut_out()), 32'h0);

        // Randomized run against the model.
        model_reset();
        rst_n = 1'b1;
        hs = 0; hp = 0; hd = 0;
        st_v = 1'b0; pa_v = 1'b0; di_v = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            check($sformatf("rand_cycle%0d {gs,lives,cd,cs,over,mv}", c), 32'(dut_out()), 32'(model_out()));
            if (hs == 0) begin st_v = ($urandom_range(0, 2) == 0); hs = $urandom_range(1, 9); end
            if (hp == 0) begin pa_v = ($urandom_range(0, 3) == 0); hp = $urandom_range(1, 9); end
            if (hd == 0) begin di_v = ($urandom_range(0, 5) == 0); hd = $urandom_range(1, 6); end
            hs--; hp--; hd--;
            gif.start_btn = st_v;
            gif.pause_btn = pa_v;
            gif.die       = di_v;
            @(posedge clk);
            model_step(st_v, pa_v, di_v);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
